// File: rtl/video_timing_rx.sv
// Video timing receiver: measures incoming sync timing, locks onto a stable
// frame format and forwards active pixels as a valid/ready stream via a FIFO.
module video_timing_rx #(
  parameter int DEPTH = 16,
  parameter int DW    = 24
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          pclk_ena,
  input  logic          hsync,
  input  logic          vsync,
  input  logic          daten,
  input  logic [DW-1:0] pdata,
  input  logic          ctrl_hsync_pol,
  input  logic          ctrl_vsync_pol,
  input  logic          ctrl_daten_pol,
  input  logic          ovf_clr,
  output logic [7:0]    m_Thsync,
  output logic [15:0]   m_Thgate,
  output logic [15:0]   m_Thlen,
  output logic [7:0]    m_Tvsync,
  output logic [15:0]   m_Tvgate,
  output logic [15:0]   m_Tvlen,
  output logic          locked,
  output logic          eof,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic          out_sof,
  output logic          out_eol,
  output logic          overflow
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {SEARCH, ALIGN, MEASURE, LOCKED} state_e;
  state_e state_q, state_d;

  logic          hs_q, vs_q, de_q, hs_p_q, vs_p_q, eof_q;
  logic [DW-1:0] pd_q;
  logic [15:0]   hcnt_q, hcnt_d, hact_q, hact_d, vcnt_q, vcnt_d, vact_q, vact_d;
  logic [15:0]   thgate_q, thgate_d, thlen_q, thlen_d, tvgate_q, tvgate_d, tvlen_q, tvlen_d;
  logic [7:0]    thsync_q, thsync_d, tvsync_q, tvsync_d;
  logic [15:0]   ref_thlen_q, ref_thlen_d, ref_tvlen_q, ref_tvlen_d;
  logic          hs_rise, hs_fall, vs_rise, vs_fall, fmt_same;
  logic [15:0]   vcnt_hs, vact_hs, thlen_new;
  logic          hold_vld_q, hold_vld_d, hold_sof_q, hold_sof_d, sof_pend_q, sof_pend_d;
  logic [DW-1:0] hold_pd_q, hold_pd_d;
  logic          fwd_en, leave, emit, emit_eol, capture;
  logic [DW+1:0] mem [DEPTH];
  logic [AW:0]   wr_ptr_q, rd_ptr_q;
  logic          fifo_empty, fifo_full, fifo_rd, fifo_wr, drop, overflow_q;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  function automatic logic [7:0] clip8(input logic [15:0] v);
    return (v > 16'd255) ? 8'hFF : v[7:0];
  endfunction

  // Registered sample and the one before it form the edge detectors.
  assign hs_rise = hs_q & ~hs_p_q;
  assign hs_fall = ~hs_q & hs_p_q;
  assign vs_rise = vs_q & ~vs_p_q;
  assign vs_fall = ~vs_q & vs_p_q;

  // An hs rise coinciding with a vs rise closes the line before the frame.
  assign vcnt_hs   = hs_rise ? sat_inc(vcnt_q) : vcnt_q;
  assign vact_hs   = (hs_rise && hact_q != '0) ? sat_inc(vact_q) : vact_q;
  assign thlen_new = hs_rise ? hcnt_q : thlen_q;
  assign fmt_same  = (thlen_new == ref_thlen_q) && (vcnt_hs == ref_tvlen_q);

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no latch is inferred.
    hcnt_d = hcnt_q;  hact_d = hact_q;  vcnt_d = vcnt_q;  vact_d = vact_q;
    thsync_d = thsync_q;  thgate_d = thgate_q;  thlen_d = thlen_q;
    tvsync_d = tvsync_q;  tvgate_d = tvgate_q;  tvlen_d = tvlen_q;
    ref_thlen_d = ref_thlen_q;  ref_tvlen_d = ref_tvlen_q;
    if (pclk_ena) begin
      hcnt_d = sat_inc(hcnt_q);
      if (de_q) hact_d = sat_inc(hact_q);
      if (hs_fall) thsync_d = clip8(hcnt_q);
      if (hs_rise) begin
        thlen_d = hcnt_q;
        hcnt_d  = 16'd1;
        if (hact_q != '0) thgate_d = hact_q;
        hact_d = {15'd0, de_q};
      end
      vcnt_d = vcnt_hs;
      vact_d = vact_hs;
      if (vs_fall) tvsync_d = clip8(vcnt_hs);
      if (vs_rise) begin
        tvlen_d     = vcnt_hs;
        tvgate_d    = vact_hs;
        vcnt_d      = '0;
        vact_d      = '0;
        ref_thlen_d = thlen_new;
        ref_tvlen_d = vcnt_hs;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    if (pclk_ena && vs_rise) begin
      case (state_q)
        SEARCH:  state_d = ALIGN;
        ALIGN:   state_d = MEASURE;
        MEASURE: if (fmt_same) state_d = LOCKED;
        LOCKED:  if (!fmt_same) state_d = SEARCH;
        default: state_d = SEARCH;
      endcase
    end
    if (state_q == LOCKED && (hcnt_q == 16'hFFFF || vcnt_q == 16'hFFFF)) state_d = SEARCH;
  end

  always_comb begin
    fwd_en = (state_q == LOCKED);
    leave  = fwd_en && (state_d != LOCKED);
  end

  // One-pixel hold lets the end-of-line marker be decided by the next sample.
  always_comb begin
    emit       = hold_vld_q && (leave || (pclk_ena && fwd_en));
    emit_eol   = leave || !de_q || hs_rise;
    capture    = pclk_ena && fwd_en && !leave && de_q;
    hold_vld_d = capture || (hold_vld_q && !emit);
    hold_pd_d  = capture ? pd_q : hold_pd_q;
    hold_sof_d = capture ? (sof_pend_q || vs_rise) : hold_sof_q;
    sof_pend_d = sof_pend_q;
    if (pclk_ena && vs_rise) sof_pend_d = 1'b1;
    if (capture) sof_pend_d = 1'b0;
  end

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign fifo_rd    = !fifo_empty && out_ready;
  assign fifo_wr    = emit && (!fifo_full || fifo_rd);
  assign drop       = emit && fifo_full && !fifo_rd;

  // NOTE: storage array carries no reset; validity is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (fifo_wr) mem[wr_ptr_q[AW-1:0]] <= {hold_sof_q, emit_eol, hold_pd_q};
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments keep every register updating from pre-edge values.
    if (rst) begin
      state_q  <= SEARCH;
      hs_q <= 1'b0;  vs_q <= 1'b0;  de_q <= 1'b0;  hs_p_q <= 1'b0;  vs_p_q <= 1'b0;
      pd_q <= '0;  eof_q <= 1'b0;
      hcnt_q <= '0;  hact_q <= '0;  vcnt_q <= '0;  vact_q <= '0;
      thsync_q <= '0;  thgate_q <= '0;  thlen_q <= '0;
      tvsync_q <= '0;  tvgate_q <= '0;  tvlen_q <= '0;
      ref_thlen_q <= '0;  ref_tvlen_q <= '0;
      hold_vld_q <= 1'b0;  hold_sof_q <= 1'b0;  hold_pd_q <= '0;  sof_pend_q <= 1'b0;
      wr_ptr_q <= '0;  rd_ptr_q <= '0;  overflow_q <= 1'b0;
    end else begin
      state_q <= state_d;
      eof_q   <= pclk_ena && (vsync ^ ctrl_vsync_pol) && !vs_q;
      if (pclk_ena) begin
        hs_p_q <= hs_q;
        vs_p_q <= vs_q;
        hs_q   <= hsync ^ ctrl_hsync_pol;
        vs_q   <= vsync ^ ctrl_vsync_pol;
        de_q   <= daten ^ ctrl_daten_pol;
        pd_q   <= pdata;
      end
      hcnt_q <= hcnt_d;  hact_q <= hact_d;  vcnt_q <= vcnt_d;  vact_q <= vact_d;
      thsync_q <= thsync_d;  thgate_q <= thgate_d;  thlen_q <= thlen_d;
      tvsync_q <= tvsync_d;  tvgate_q <= tvgate_d;  tvlen_q <= tvlen_d;
      ref_thlen_q <= ref_thlen_d;  ref_tvlen_q <= ref_tvlen_d;
      hold_vld_q <= hold_vld_d;  hold_sof_q <= hold_sof_d;  hold_pd_q <= hold_pd_d;
      sof_pend_q <= sof_pend_d;
      if (fifo_wr) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (fifo_rd) rd_ptr_q <= rd_ptr_q + 1'b1;
      if (drop) overflow_q <= 1'b1;
      else if (ovf_clr) overflow_q <= 1'b0;
    end
  end

  assign {out_sof, out_eol, out_data} = fifo_empty ? '0 : mem[rd_ptr_q[AW-1:0]];
  assign out_valid = !fifo_empty;
  assign overflow  = overflow_q;
  assign locked    = fwd_en;
  assign eof       = eof_q;
  assign m_Thsync  = thsync_q;
  assign m_Thgate  = thgate_q;
  assign m_Thlen   = thlen_q;
  assign m_Tvsync  = tvsync_q;
  assign m_Tvgate  = tvgate_q;
  assign m_Tvlen   = tvlen_q;
endmodule
